chunked_comparator: RTL

Parametrised multi-cycle magnitude comparator: the next generation of the team's 4-bit combinational comparator. It compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first, and terminates early at the first differing chunk. It supports unsigned and two's-complement signed modes through a start/busy/done handshake, and reports registered lt/gt/eq results plus the number of chunks examined. It is intended for wide datapath comparisons where a single-cycle WIDTH-bit compare would limit timing.

---
 rtl/chunked_comparator.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/chunked_comparator.sv
// Multi-cycle magnitude comparator: compares two WIDTH-bit operands CHUNK bits per
// cycle, MSB chunk first, stopping at the first differing chunk.
module chunked_comparator #(
    parameter  int WIDTH  = 16,
    parameter  int CHUNK  = 4,
    localparam int NCHUNK = WIDTH / CHUNK,
    localparam int CW     = $clog2(NCHUNK + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_mode,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              busy,
    output logic              done,
    output logic              lt,
    output logic              gt,
    output logic              eq,
    output logic [CW-1:0]     cycles
);

    localparam int KW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int NSLOT = 1 << KW;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [KW-1:0]     k_reg, k_next;
    logic [WIDTH-1:0]  a_reg, a_next;
    logic [WIDTH-1:0]  b_reg, b_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              lt_reg, lt_next;
    logic              gt_reg, gt_next;
    logic              eq_reg, eq_next;
    logic [CW-1:0]     cycles_reg, cycles_next;

    // Chunk views of the captured operands, padded to a power-of-two table so the
    // chunk index can address it directly without any width adaptation.
    logic [CHUNK-1:0]  a_chunk [NSLOT];
    logic [CHUNK-1:0]  b_chunk [NSLOT];
    logic [CHUNK-1:0]  a_cur;
    logic [CHUNK-1:0]  b_cur;

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_chunk
            if (gi < NCHUNK) begin : g_real
                assign a_chunk[gi] = a_reg[WIDTH-1-gi*CHUNK -: CHUNK];
                assign b_chunk[gi] = b_reg[WIDTH-1-gi*CHUNK -: CHUNK];
            end else begin : g_pad
                assign a_chunk[gi] = '0;
                assign b_chunk[gi] = '0;
            end
        end
    endgenerate

    assign a_cur = a_chunk[k_reg];
    assign b_cur = b_chunk[k_reg];

    always_comb begin
        state_next  = state_reg;
        k_next      = k_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;
        lt_next     = lt_reg;
        gt_next     = gt_reg;
        eq_next     = eq_reg;
        cycles_next = cycles_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    // Flipping the sign bit maps two's-complement order onto unsigned order.
                    a_next             = a;
                    b_next             = b;
                    a_next[WIDTH-1]    = a[WIDTH-1] ^ signed_mode;
                    b_next[WIDTH-1]    = b[WIDTH-1] ^ signed_mode;
                    lt_next            = 1'b0;
                    gt_next            = 1'b0;
                    eq_next            = 1'b0;
                    cycles_next        = '0;
                    busy_next          = 1'b1;
                    k_next             = '0;
                    state_next         = RUN;
                end
            end
            RUN: begin
                if (a_cur != b_cur) begin
                    lt_next     = (a_cur < b_cur);
                    gt_next     = (a_cur > b_cur);
                    cycles_next = CW'(k_reg) + CW'(1);
                    done_next   = 1'b1;
                    busy_next   = 1'b0;
                    state_next  = IDLE;
                end else if (k_reg == KW'(NCHUNK - 1)) begin
                    eq_next     = 1'b1;
                    cycles_next = CW'(NCHUNK);
                    done_next   = 1'b1;
                    busy_next   = 1'b0;
                    state_next  = IDLE;
                end else begin
                    k_next = k_reg + KW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            k_reg      <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            lt_reg     <= 1'b0;
            gt_reg     <= 1'b0;
            eq_reg     <= 1'b0;
            cycles_reg <= '0;
        end else begin
            state_reg  <= state_next;
            k_reg      <= k_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            lt_reg     <= lt_next;
            gt_reg     <= gt_next;
            eq_reg     <= eq_next;
            cycles_reg <= cycles_next;
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign lt     = lt_reg;
    assign gt     = gt_reg;
    assign eq     = eq_reg;
    assign cycles = cycles_reg;

endmodule
